// File: rtl/matmul_flag_collector.sv
// matmul_flag_collector: gathers per-PE overflow flags during a matmul and
// emits a one-cycle write of the packed flag vector when every active cell
// has retired its final accumulation or the watchdog expires.
module matmul_flag_collector #(
    parameter int DATA_WIDTH     = 32,
    parameter int BUS_WIDTH      = 64,
    parameter int MAX_DIM        = BUS_WIDTH / DATA_WIDTH,
    parameter int DIM_W          = $clog2(MAX_DIM) + 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         start_i,
    input  logic [DIM_W-1:0]             dim_n_i,
    input  logic [DIM_W-1:0]             dim_m_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]   pe_valid_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]   pe_ovf_i,
    input  logic [MAX_DIM*MAX_DIM-1:0]   pe_last_i,
    output logic                         busy_o,
    output logic                         write_enable_o,
    output logic [BUS_WIDTH-1:0]         data_o,
    output logic                         timeout_o
);

    localparam int NCELL = MAX_DIM * MAX_DIM;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NCELL-1:0] flags_q, flags_d;
    logic [NCELL-1:0] done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIM_W-1:0] dim_n_q, dim_n_d;
    logic [DIM_W-1:0] dim_m_q, dim_m_d;
    logic             timeout_q, timeout_d;

    logic [NCELL-1:0] active_mask;
    logic [NCELL-1:0] qual_ovf;
    logic [NCELL-1:0] qual_last;
    logic             complete;
    logic             expired;
    logic [DIM_W-1:0] n_clamped;
    logic [DIM_W-1:0] m_clamped;

    // Oversized dimensions saturate to the array size.
    assign n_clamped = (dim_n_i > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : dim_n_i;
    assign m_clamped = (dim_m_i > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : dim_m_i;

    // Cell (r,c) participates only inside the latched n x m window.
    for (genvar gi = 0; gi < MAX_DIM; gi++) begin : g_row
        for (genvar gj = 0; gj < MAX_DIM; gj++) begin : g_col
            assign active_mask[gi*MAX_DIM+gj] =
                (dim_n_q > DIM_W'(gi)) && (dim_m_q > DIM_W'(gj));
        end
    end

    assign qual_ovf  = pe_valid_i & pe_ovf_i  & active_mask;
    assign qual_last = pe_valid_i & pe_last_i & active_mask;

    // Completion looks at this cycle's last markers too, so the final
    // retirement edge already moves to WRITE (an empty mask completes at once).
    assign complete = (((done_q | qual_last) & active_mask) == active_mask);
    assign expired  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state logic for the FSM and the collection registers.
    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        done_d    = done_q;
        cnt_d     = cnt_q;
        dim_n_d   = dim_n_q;
        dim_m_d   = dim_m_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    dim_n_d   = n_clamped;
                    dim_m_d   = m_clamped;
                    flags_d   = '0;
                    done_d    = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                flags_d = flags_q | qual_ovf;
                done_d  = done_q | qual_last;
                cnt_d   = cnt_q + CNT_W'(1);
                if (complete) begin
                    timeout_d = 1'b0;
                    state_d   = ST_WRITE;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            flags_q   <= '0;
            done_q    <= '0;
            cnt_q     <= '0;
            dim_n_q   <= '0;
            dim_m_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
            dim_n_q   <= dim_n_d;
            dim_m_q   <= dim_m_d;
            timeout_q <= timeout_d;
        end
    end

    // Outputs decode registered state only; no path from the PE inputs.
    assign busy_o         = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
    assign write_enable_o = (state_q == ST_WRITE);
    assign data_o         = write_enable_o ? BUS_WIDTH'(flags_q) : '0;
    assign timeout_o      = write_enable_o & timeout_q;

endmodule

// File: tb/tb_matmul_flag_collector.sv
// Directed testbench for matmul_flag_collector (2x2 array, watchdog of 8).
module tb_matmul_flag_collector;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  dim_n_i;
    logic [1:0]  dim_m_i;
    logic [3:0]  pe_valid_i;
    logic [3:0]  pe_ovf_i;
    logic [3:0]  pe_last_i;
    logic        busy_o;
    logic        write_enable_o;
    logic [63:0] data_o;
    logic        timeout_o;

    int n_total = 0;
    int n_bad   = 0;

    matmul_flag_collector #(
        .DATA_WIDTH(32),
        .BUS_WIDTH(64),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .start_i(start_i),
        .dim_n_i(dim_n_i),
        .dim_m_i(dim_m_i),
        .pe_valid_i(pe_valid_i),
        .pe_ovf_i(pe_ovf_i),
        .pe_last_i(pe_last_i),
        .busy_o(busy_o),
        .write_enable_o(write_enable_o),
        .data_o(data_o),
        .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    // Compare one observed value against its expectation.
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pe(input logic [3:0] v, input logic [3:0] o, input logic [3:0] l);
        pe_valid_i = v;
        pe_ovf_i   = o;
        pe_last_i  = l;
    endtask

    task automatic do_start(input logic [1:0] n, input logic [1:0] m);
        start_i = 1'b1;
        dim_n_i = n;
        dim_m_i = m;
        step();
        start_i = 1'b0;
    endtask

    initial begin
        rst_ni  = 1'b0;
        start_i = 1'b0;
        dim_n_i = '0;
        dim_m_i = '0;
        pe(4'h0, 4'h0, 4'h0);
        step();
        step();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_we", 64'(write_enable_o), 64'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_to", 64'(timeout_o), 64'd0);
        rst_ni = 1'b1;
        step();

        // Full 2x2, all last in one cycle, no overflow.
        do_start(2'd2, 2'd2);
        chk("t1_busy", 64'(busy_o), 64'd1);
        chk("t1_we_early", 64'(write_enable_o), 64'd0);
        pe(4'hF, 4'h0, 4'hF);
        step();
        pe(4'h0, 4'h0, 4'h0);
        chk("t1_we", 64'(write_enable_o), 64'd1);
        chk("t1_data", data_o, 64'h0);
        chk("t1_to", 64'(timeout_o), 64'd0);
        step();
        chk("t1_we_off", 64'(write_enable_o), 64'd0);
        chk("t1_busy_off", 64'(busy_o), 64'd0);

        // Staggered 2x2 with sticky overflow on cell 0 and final ovf on cell 3.
        do_start(2'd2, 2'd2);
        pe(4'h1, 4'h1, 4'h0);
        step();
        pe(4'h0, 4'h0, 4'h0);
        step();
        chk("t2_wait", 64'(write_enable_o), 64'd0);
        pe(4'hF, 4'h8, 4'hF);
        step();
        pe(4'h0, 4'h0, 4'h0);
        chk("t2_we", 64'(write_enable_o), 64'd1);
        chk("t2_data", data_o, 64'h9);
        step();
        chk("t2_data_off", data_o, 64'h0);

        // Partial 1x2: inactive cells 2,3 neither flag nor complete.
        do_start(2'd1, 2'd2);
        pe(4'hC, 4'hF, 4'hF);
        step();
        chk("t3_inactive", 64'(write_enable_o), 64'd0);
        pe(4'hF, 4'hF, 4'hF);
        step();
        pe(4'h0, 4'h0, 4'h0);
        chk("t3_we", 64'(write_enable_o), 64'd1);
        chk("t3_data", data_o, 64'h3);
        step();

        // Zero dimension completes on the first COLLECT edge.
        do_start(2'd0, 2'd2);
        chk("t4_busy", 64'(busy_o), 64'd1);
        chk("t4_we_early", 64'(write_enable_o), 64'd0);
        step();
        chk("t4_we", 64'(write_enable_o), 64'd1);
        chk("t4_data", data_o, 64'h0);
        step();

        // Oversize dims clamp to 2x2, so cell 2 is active.
        do_start(2'd3, 2'd3);
        pe(4'hF, 4'h4, 4'hF);
        step();
        pe(4'h0, 4'h0, 4'h0);
        chk("t5_we", 64'(write_enable_o), 64'd1);
        chk("t5_data", data_o, 64'h4);
        step();

        // Watchdog: cell 1 never retires; 8 COLLECT cycles then a forced write.
        do_start(2'd1, 2'd2);
        pe(4'h1, 4'h1, 4'h1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("t6_busy_c%0d", i), 64'(busy_o), 64'd1);
            chk($sformatf("t6_we_c%0d", i), 64'(write_enable_o), 64'd0);
            step();
            pe(4'h0, 4'h0, 4'h0);
        end
        chk("t6_we", 64'(write_enable_o), 64'd1);
        chk("t6_to", 64'(timeout_o), 64'd1);
        chk("t6_data", data_o, 64'h1);
        chk("t6_busy9", 64'(busy_o), 64'd1);
        step();
        chk("t6_busy_off", 64'(busy_o), 64'd0);
        chk("t6_to_off", 64'(timeout_o), 64'd0);

        // Reset mid-COLLECT discards state and issues no strobe.
        do_start(2'd2, 2'd2);
        pe(4'h1, 4'h1, 4'h0);
        step();
        pe(4'h0, 4'h0, 4'h0);
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("t7_busy", 64'(busy_o), 64'd0);
        chk("t7_we", 64'(write_enable_o), 64'd0);
        chk("t7_data", data_o, 64'h0);
        step();
        chk("t7_no_strobe", 64'(write_enable_o), 64'd0);
        do_start(2'd2, 2'd2);
        pe(4'hF, 4'h0, 4'hF);
        step();
        pe(4'h0, 4'h0, 4'h0);
        chk("t7_cleared", data_o, 64'h0);
        chk("t7_we2", 64'(write_enable_o), 64'd1);
        step();

        // Start during COLLECT is ignored; start during WRITE is dropped.
        do_start(2'd2, 2'd2);
        pe(4'h1, 4'h1, 4'h0);
        step();
        pe(4'h0, 4'h0, 4'h0);
        do_start(2'd0, 2'd0);
        chk("t8_still_busy", 64'(write_enable_o), 64'd0);
        pe(4'hF, 4'h0, 4'hF);
        step();
        pe(4'h0, 4'h0, 4'h0);
        chk("t8_we", 64'(write_enable_o), 64'd1);
        chk("t8_data", data_o, 64'h1);
        do_start(2'd2, 2'd2);
        chk("t8_drop_busy", 64'(busy_o), 64'd0);
        step();
        chk("t8_drop_we", 64'(write_enable_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
